// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch FSM encoding, instruction field positions and default PC step.
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, HOLD} fetch_state_t;
   localparam logic [31:0] DEF_PC_STEP = 32'd4;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNC_MSB = 4;
   localparam int FUNC_LSB = 0;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
endpackage

// File: rtl/instr_reg.sv
// instr_reg: 32-bit instruction register with load/clear and opcode/func/imm16 extraction.
module instr_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] d,
   output logic [31:0] q,
   output logic [5:0]  opcode,
   output logic [4:0]  func,
   output logic [15:0] imm16
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clear) q <= '0;
      else if (load) q <= d;
   assign opcode = q[OPCODE_MSB:OPCODE_LSB];
   assign func   = q[FUNC_MSB:FUNC_LSB];
   assign imm16  = q[IMM_MSB:IMM_LSB];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch FSM with redirect/kill and a
// valid/ready handoff to decode.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [5:0]  opcode,
   output logic [4:0]  func,
   output logic [15:0] imm16,
   output logic [31:0] instr_pc
);
   fetch_state_t state, state_n;
   logic [31:0] pc, pc_n, unused_ir;
   logic kill, kill_n, load;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         kill     <= 1'b0;
         instr_pc <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         kill  <= kill_n;
         if (load) instr_pc <= pc;
      end
   always_comb begin
      state_n = state;
      pc_n    = pc;
      load    = imem_ack && !redirect && (state == REQ || (state == WAIT_ACK && !kill));
      // a redirect while waiting leaves one stale ack in flight that must be swallowed
      kill_n  = state == WAIT_ACK && !imem_ack && (kill || redirect);
      if (redirect) begin
         pc_n    = redirect_pc;
         state_n = (state == WAIT_ACK && !imem_ack) ? WAIT_ACK : halt ? IDLE : REQ;
      end else begin
         unique case (state)
            IDLE:     state_n = halt ? IDLE : REQ;
            REQ:      state_n = imem_ack ? HOLD : WAIT_ACK;
            WAIT_ACK: state_n = (imem_ack && !kill) ? HOLD : WAIT_ACK;
            HOLD: if (instr_ready) begin
               pc_n    = pc + PC_STEP;
               state_n = halt ? IDLE : REQ;
            end
            default:  state_n = IDLE;
         endcase
      end
   end
   assign imem_req    = state == REQ || state == WAIT_ACK;
   assign imem_addr   = pc;
   assign instr_valid = state == HOLD;
   instr_reg u_ir (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .clear  (redirect),
      .d      (imem_rdata),
      .q      (unused_ir),
      .opcode (opcode),
      .func   (func),
      .imm16  (imm16)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the fetch protocol.
module tb_instr_fetch_unit;
   logic clk = 1'b0, rst_n = 1'b0;
   logic imem_req, imem_ack = 1'b0, redirect = 1'b0, halt = 1'b1;
   logic instr_valid, instr_ready = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, instr_pc;
   logic [5:0] opcode;
   logic [4:0] func;
   logic [15:0] imm16;
   int checks = 0, errors = 0;
   // model: phase 0 idle, 1 request issued, 2 waiting, 3 holding an instruction
   int mst;
   logic [31:0] mpc, mir, mipc;
   bit mkill;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .opcode(opcode), .func(func), .imm16(imm16),
      .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mst = 0; mpc = 32'h0; mkill = 0; mir = '0; mipc = '0;
   endtask

   task automatic step(input logic a, input logic [31:0] d, input logic r,
                       input logic [31:0] rp, input logic h, input logic rd);
      imem_ack = a; imem_rdata = d; redirect = r; redirect_pc = rp; halt = h; instr_ready = rd;
      chk("imem_req", imem_req, 32'(mst == 1 || mst == 2));
      if (mst == 1 || mst == 2) chk("imem_addr", imem_addr, mpc);
      chk("instr_valid", instr_valid, 32'(mst == 3));
      if (mst == 3) begin
         chk("opcode", opcode, mir[31:26]);
         chk("func", func, mir[4:0]);
         chk("imm16", imm16, mir[15:0]);
         chk("instr_pc", instr_pc, mipc);
      end
      @(posedge clk);
      if (r) begin
         if (mst == 2 && !a) mkill = 1;
         else begin mkill = 0; mst = h ? 0 : 1; end
         mpc = rp;
      end else if (mst == 0) mst = h ? 0 : 1;
      else if (mst == 1) begin
         if (a) begin mir = d; mipc = mpc; mst = 3; end else mst = 2;
      end else if (mst == 2) begin
         if (a && mkill) mkill = 0;
         else if (a) begin mir = d; mipc = mpc; mst = 3; end
      end else if (rd) begin
         mpc = mpc + 32'd4; mst = h ? 0 : 1;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; imem_ack = 0; redirect = 0; halt = 1; instr_ready = 0;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_ir", {opcode, func, imm16}, 0);
      chk("rst_instr_pc", instr_pc, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [31:0] addrs[$];
      logic [31:0] got, saved_pc;
      logic [26:0] saved_f;
      int nvalid;
      logic h, a, r, rd;
      model_reset();
      @(negedge clk);
      // first fetch after reset, ack after two cycles
      apply_reset();
      step(0, 0, 0, 0, 0, 0);
      chk("t34_req", imem_req, 1);
      chk("t34_addr", imem_addr, 32'h0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 32'h08A3_FFFF, 0, 0, 0, 0);
      chk("t34_valid", instr_valid, 1);
      chk("t34_opcode", opcode, 6'b000010);
      chk("t34_func", func, 5'h1F);
      chk("t34_imm16", imm16, 16'hFFFF);
      chk("t34_instr_pc", instr_pc, 32'h0);
      // zero-wait memory with decode always ready
      apply_reset();
      step(0, 0, 0, 0, 0, 1);
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         if (imem_req) addrs.push_back(imem_addr);
         if (instr_valid) nvalid++;
         step(imem_req, $urandom, 0, 0, 0, 1);
      end
      chk("t35_nreq", addrs.size(), 4);
      chk("t35_nvalid", nvalid, 4);
      for (int k = 0; k < 4; k++) begin
         got = (k < addrs.size()) ? addrs[k] : 32'hxxxx_xxxx;
         chk("t35_addr", got, 32'(4 * k));
      end
      // decode stalls five cycles; stray acks in HOLD are ignored
      step(1, 32'hA5C3_1E2D, 0, 0, 0, 0);
      saved_f = {opcode, func, imm16};
      saved_pc = instr_pc;
      for (int i = 0; i < 5; i++) begin
         step(i[0], $urandom, 0, 0, 0, 0);
         chk("t36_noreq", imem_req, 0);
         chk("t36_stable", {opcode, func, imm16}, saved_f);
         chk("t36_pc_stable", instr_pc, saved_pc);
      end
      step(0, 0, 0, 0, 0, 1);
      chk("t36_next_addr", imem_addr, saved_pc + 32'd4);
      // redirect while waiting on address 0x8 kills the in-flight ack
      apply_reset();
      step(0, 0, 0, 0, 0, 0);
      step(1, $urandom, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(1, $urandom, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t37_wait_addr", imem_addr, 32'h8);
      step(0, 0, 1, 32'h100, 0, 0);
      chk("t37_req_held", imem_req, 1);
      chk("t37_new_addr", imem_addr, 32'h100);
      step(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      chk("t37_dropped", instr_valid, 0);
      step(1, 32'h1234_5678, 0, 0, 0, 0);
      chk("t37_valid", instr_valid, 1);
      chk("t37_instr_pc", instr_pc, 32'h100);
      chk("t37_imm16", imm16, 16'h5678);
      // PC wraps past the top of the address space
      step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      chk("t38_valid_drop", instr_valid, 0);
      step(1, $urandom, 0, 0, 0, 0);
      chk("t38_instr_pc", instr_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0, 0, 1);
      chk("t38_wrap_addr", imem_addr, 32'h0);
      // redirect coinciding with ack: data dropped, no kill left behind
      step(0, 0, 0, 0, 0, 0);
      step(1, 32'h0BAD_0BAD, 1, 32'h200, 0, 0);
      chk("t27_valid", instr_valid, 0);
      step(1, 32'h00C0_FFEE, 0, 0, 0, 0);
      chk("t27_instr_pc", instr_pc, 32'h200);
      chk("t27_imm16", imm16, 16'hFFEE);
      // reset mid-request, then a late ack in IDLE
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("t39_req_before", imem_req, 1);
      apply_reset();
      step(1, 32'h7777_7777, 0, 0, 1, 1);
      chk("t39_late_valid", instr_valid, 0);
      chk("t39_late_req", imem_req, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("t39_restart", imem_addr, 32'h0);
      // randomized traffic against the model
      h = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) h = ~h;
         a = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 15) == 0;
         rd = $urandom_range(0, 1) == 1;
         step(a, $urandom, r, $urandom & 32'hFFFF_FFFC, h, rd);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
